uart_gpio_bridge: RTL and testbench



---
 rtl/uart_gpio_bridge_pkg.sv | 97 +++++++++
 rtl/uart_gpio_bridge_rx.sv | 104 ++++++++++
 rtl/uart_gpio_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_uart_gpio_bridge.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_gpio_bridge_pkg.sv
// Shared constants, state encodings and byte-lane helpers for the UART-to-GPIO bridge.
package uart_gpio_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam logic [7:0] ADDR_OUT = 8'h00;
  localparam logic [7:0] ADDR_OE  = 8'h08;
  localparam logic [7:0] ADDR_IN  = 8'h10;

  localparam int GPIO_W = 46;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ADDR,
    C_DATA
  } cmd_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_LOAD,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    REG_OUT,
    REG_OE,
    REG_IN,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    rx_state_e  rx;
    cmd_state_e cmd;
    tx_state_e  tx;
    logic       tx_pad_in;
  } dbg_t;

  // Each bank is six bytes starting on an 8-byte boundary; lanes 6 and 7 are holes.
  function automatic reg_sel_e decode_sel(input logic [7:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[2:0] <= 3'd5) begin
      case (addr[7:3])
        ADDR_OUT[7:3]: sel = REG_OUT;
        ADDR_OE[7:3]:  sel = REG_OE;
        ADDR_IN[7:3]:  sel = REG_IN;
        default:       sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [7:0] get_byte(input logic [GPIO_W-1:0] v, input logic [2:0] idx);
    logic [47:0] pad;
    logic [7:0]  b;
    pad = {2'b00, v};
    case (idx)
      3'd0:    b = pad[7:0];
      3'd1:    b = pad[15:8];
      3'd2:    b = pad[23:16];
      3'd3:    b = pad[31:24];
      3'd4:    b = pad[39:32];
      3'd5:    b = pad[47:40];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [GPIO_W-1:0] set_byte(input logic [GPIO_W-1:0] v,
                                                 input logic [2:0]        idx,
                                                 input logic [7:0]        b);
    logic [47:0] pad;
    pad = {2'b00, v};
    case (idx)
      3'd0:    pad[7:0]   = b;
      3'd1:    pad[15:8]  = b;
      3'd2:    pad[23:16] = b;
      3'd3:    pad[31:24] = b;
      3'd4:    pad[39:32] = b;
      3'd5:    pad[47:40] = b;
      default: pad = pad;
    endcase
    return GPIO_W'(pad);
  endfunction

endpackage

// File: rtl/uart_gpio_bridge_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; expects an already synchronized line.
module uart_rx
  import uart_gpio_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o,
  output rx_state_e  state_o
);

  localparam int CW = 12;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_i) state_d = R_START;
      end
      R_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_i ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_i, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = R_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_i) begin
            valid_d = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_WAIT_HIGH;
          end
        end
      end
      R_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_i) state_d = R_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = R_IDLE;
      end
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = shift_q;
  assign rx_ferr_o  = ferr_q;
  assign state_o    = state_q;

endmodule

// File: rtl/uart_gpio_bridge.sv
// UART command port on pins 0/1 giving a host byte-wide access to the other 46 pins
// (output values, output enables, synchronized inputs).
module uart_gpio_bridge
  import uart_gpio_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] io_in,
  output logic [47:0] io_out,
  output logic [47:0] io_oeb
);

  localparam int CW = 12;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);

  // Input synchronizer; RX resets high so reset release never looks like a start bit.
  logic [47:0] sync_q [SYNC_STAGES];
  logic [47:0] in_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 48'h1;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] rx_byte;
  rx_state_e  rx_state;

  uart_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (in_s[0]),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .rx_ferr_o  (rx_ferr),
    .state_o    (rx_state)
  );

  cmd_state_e         cmd_q, cmd_d;
  logic               op_write_q, op_write_d;
  logic [7:0]         addr_q, addr_d;
  logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0]  oe_q, oe_d;
  logic               tx_load;
  logic [7:0]         reply_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q      <= C_IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      gpio_out_q <= '0;
      oe_q       <= '0;
    end else begin
      cmd_q      <= cmd_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      gpio_out_q <= gpio_out_d;
      oe_q       <= oe_d;
    end
  end

  // Read data is looked up from the address byte itself, so it is ready on the same edge.
  always_comb begin
    reply_byte = 8'h00;
    case (decode_sel(rx_byte))
      REG_OUT: reply_byte = get_byte(gpio_out_q, rx_byte[2:0]);
      REG_OE:  reply_byte = get_byte(oe_q, rx_byte[2:0]);
      REG_IN:  reply_byte = get_byte(in_s[47:2], rx_byte[2:0]);
      default: reply_byte = 8'h00;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    gpio_out_d = gpio_out_q;
    oe_d       = oe_q;
    tx_load    = 1'b0;
    if (rx_ferr) begin
      cmd_d = C_IDLE;
    end else if (rx_valid) begin
      case (cmd_q)
        C_IDLE: begin
          if (rx_byte == CMD_WRITE) begin
            cmd_d      = C_ADDR;
            op_write_d = 1'b1;
          end else if (rx_byte == CMD_READ) begin
            cmd_d      = C_ADDR;
            op_write_d = 1'b0;
          end
        end
        C_ADDR: begin
          addr_d = rx_byte;
          if (op_write_q) begin
            cmd_d = C_DATA;
          end else begin
            tx_load = 1'b1;
            cmd_d   = C_IDLE;
          end
        end
        C_DATA: begin
          cmd_d = C_IDLE;
          case (decode_sel(addr_q))
            REG_OUT: gpio_out_d = set_byte(gpio_out_q, addr_q[2:0], rx_byte);
            REG_OE:  oe_d       = set_byte(oe_q, addr_q[2:0], rx_byte);
            default: ;
          endcase
        end
        default: cmd_d = C_IDLE;
      endcase
    end
  end

  // TX: T_LOAD holds the line idle for the capture cycle so the start bit follows one edge later.
  tx_state_e      tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_line_q, tx_line_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 12'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (tx_load) begin
          tx_shift_d = reply_byte;
          tx_state_d = T_LOAD;
        end
      end
      T_LOAD: begin
        tx_cnt_d   = '0;
        tx_line_d  = 1'b0;
        tx_state_d = T_START;
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_line_d  = 1'b1;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  // Snapshot of all FSM states plus the TX pad readback, kept for debug probing only.
  dbg_t dbg_unused;
  assign dbg_unused = '{rx: rx_state, cmd: cmd_q, tx: tx_state_q, tx_pad_in: in_s[1]};

  assign io_out = {gpio_out_q, tx_line_q, 1'b0};
  assign io_oeb = {~oe_q, 1'b0, 1'b1};

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Self-checking bench for uart_gpio_bridge: UART host driver, TX frame capture and a register-map model.
module tb_uart_gpio_bridge;
  import uart_gpio_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int FRAME   = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line = 1'b1;
  logic [45:0] gpio_in_drv = '0;
  logic [47:0] io_in;
  logic [47:0] io_out;
  logic [47:0] io_oeb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model of the host-visible registers; bits 47:46 always zero.
  logic [47:0] m_out = '0;
  logic [47:0] m_oe  = '0;

  assign io_in = {gpio_in_drv, 1'b0, rx_line};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_gpio_bridge #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle=%0d, want < 300000)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_read(input logic [7:0] addr);
    int a;
    logic [47:0] in_w;
    a = int'(addr);
    in_w = {2'b00, gpio_in_drv};
    if (a <= 5)                return 8'(m_out >> (8 * a));
    if (a >= 8 && a <= 13)     return 8'(m_oe >> (8 * (a - 8)));
    if (a >= 16 && a <= 21)    return 8'(in_w >> (8 * (a - 16)));
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    int a;
    a = int'(addr);
    if (a <= 5)            m_out[8*a +: 8] = data;
    if (a >= 8 && a <= 13) m_oe[8*(a-8) +: 8] = data;
    m_out[47:46] = 2'b00;
    m_oe[47:46]  = 2'b00;
  endtask

  function automatic logic [FRAME:0] frame_wave(input logic [7:0] b);
    logic [FRAME:0] w;
    for (int i = 0; i <= FRAME; i++) begin
      int slot;
      slot = i / CLK_DIV;
      if (slot == 0)      w[i] = 1'b0;
      else if (slot <= 8) w[i] = b[slot-1];
      else                w[i] = 1'b1;
    end
    return w;
  endfunction

  // ---------------- drivers / monitors ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic capture_tx(output logic [FRAME:0] wave, output bit got, output int t0);
    int n;
    n = 0;
    got = 1'b0;
    wave = '0;
    t0 = 0;
    while (io_out[1] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (io_out[1] === 1'b0) begin
      got = 1'b1;
      t0 = cyc;
      for (int i = 0; i <= FRAME; i++) begin
        wave[i] = io_out[1];
        @(negedge clk);
      end
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    send_byte(CMD_WRITE);
    send_byte(addr);
    send_byte(data);
    model_write(addr, data);
  endtask

  task automatic check_pins(input string name);
    total++;
    if (io_out !== {m_out[45:0], 2'b10}) begin
      bad++;
      $display("FAIL %s_io_out: got %h want %h", name, io_out, {m_out[45:0], 2'b10});
    end
    total++;
    if (io_oeb !== {~m_oe[45:0], 2'b01}) begin
      bad++;
      $display("FAIL %s_io_oeb: got %h want %h", name, io_oeb, {~m_oe[45:0], 2'b01});
    end
  endtask

  task automatic read_check(input string name, input logic [7:0] addr);
    logic [7:0]     exp_b;
    logic [7:0]     got_b;
    logic [FRAME:0] wave;
    bit             got;
    int             t0;
    int             ts;
    int             lat;
    exp_b = model_read(addr);
    send_byte(CMD_READ);
    ts = cyc;
    fork
      send_byte(addr);
      capture_tx(wave, got, t0);
    join
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: no TX start bit seen (got=%0d want=1)", name, got);
    end else begin
      for (int k = 0; k < 8; k++) got_b[k] = wave[CLK_DIV*(k+1) + CLK_DIV/2];
      total++;
      if (got_b !== exp_b) begin
        bad++;
        $display("FAIL %s_data: addr %h got %h want %h", name, addr, got_b, exp_b);
      end
      total++;
      if (wave !== frame_wave(exp_b)) begin
        bad++;
        $display("FAIL %s_wave: got %h want %h", name, wave, frame_wave(exp_b));
      end
      lat = t0 - ts;
      total++;
      if (lat < 9 * CLK_DIV || lat > 10 * CLK_DIV) begin
        bad++;
        $display("FAIL %s_latency: got %0d want %0d..%0d", name, lat, 9 * CLK_DIV, 10 * CLK_DIV);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (io_out !== 48'h0000_0000_0002) begin
      bad++;
      $display("FAIL reset_io_out: got %h want %h", io_out, 48'h2);
    end
    total++;
    if (io_oeb !== 48'hFFFF_FFFF_FFFD) begin
      bad++;
      $display("FAIL reset_io_oeb: got %h want %h", io_oeb, 48'hFFFF_FFFF_FFFD);
    end
    rst_n = 1'b1;
    m_out = '0;
    m_oe  = '0;
    repeat (8) @(negedge clk);
    check_pins("post_reset");
  endtask

  task automatic test_write_drive();
    write_reg(8'h08, 8'hFF);
    write_reg(8'h00, 8'hA5);
    total++;
    if (io_oeb[9:2] !== 8'h00) begin
      bad++;
      $display("FAIL wr_oe_byte0: got %h want %h", io_oeb[9:2], 8'h00);
    end
    total++;
    if (io_out[9:2] !== 8'hA5) begin
      bad++;
      $display("FAIL wr_out_byte0: got %h want %h", io_out[9:2], 8'hA5);
    end
    check_pins("wr_drive");
  endtask

  task automatic test_read_input();
    gpio_in_drv[15:8] = 8'h3C;
    repeat (5) @(negedge clk);
    read_check("rd_in_11", 8'h11);
  endtask

  task automatic test_framing();
    send_byte(CMD_WRITE);
    send_frame(8'h00, 1'b0);
    repeat (40) @(negedge clk);
    check_pins("ferr_nowrite");
    read_check("ferr_read00", 8'h00);
  endtask

  task automatic test_edges();
    read_check("rd_hole_20", 8'h20);
    write_reg(8'h05, 8'hFF);
    check_pins("wr_top_byte");
    read_check("rd_top_05", 8'h05);
    write_reg(8'h12, 8'h77);
    check_pins("wr_readonly");
  endtask

  task automatic test_glitch();
    send_byte(CMD_WRITE);
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h5A);
    model_write(8'h00, 8'h5A);
    check_pins("glitch");
  endtask

  task automatic test_random();
    logic [7:0] addr;
    logic [7:0] junk;
    for (int it = 0; it < 16; it++) begin
      gpio_in_drv = {14'($urandom), 32'($urandom)};
      repeat (4) @(negedge clk);
      if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 255));
      else                           addr = 8'($urandom_range(0, 23));
      if ($urandom_range(0, 4) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == CMD_WRITE || junk == CMD_READ) junk = 8'h00;
        send_byte(junk);
      end
      if ($urandom_range(0, 1) == 0) begin
        write_reg(addr, 8'($urandom_range(0, 255)));
        check_pins("rand_wr");
      end else begin
        read_check("rand_rd", addr);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    write_reg(8'h01, 8'h96);
    send_byte(CMD_READ);
    fork
      send_byte(8'h01);
      begin
        n = 0;
        while (io_out[1] !== 1'b0 && n < 400) begin
          @(negedge clk);
          n++;
        end
      end
    join
    total++;
    if (io_out[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_start: got %b want 0", io_out[1]);
    end else begin
      // first negedge of the start bit has passed; move into the middle of data bit 3
      repeat (4 * CLK_DIV + CLK_DIV / 2 - 2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (io_out !== 48'h0000_0000_0002) begin
        bad++;
        $display("FAIL rst_mid_tx: got %h want %h", io_out, 48'h2);
      end
      rst_n = 1'b1;
      m_out = '0;
      m_oe  = '0;
    end
    repeat (2 * FRAME) @(negedge clk);
    check_pins("rst_mid_after");
    gpio_in_drv[23:16] = 8'hC3;
    repeat (4) @(negedge clk);
    read_check("rst_mid_read", 8'h12);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_drive();
    test_read_input();
    test_framing();
    test_edges();
    test_glitch();
    test_random();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
